spectrum_peak_tracker: RTL

//   Streaming successor to the parallel 16-bin max-finder in the FAS analysis path.

---
 rtl/spectrum_peak_tracker.sv | 131 +++++++++++++
 1 files changed

// File: rtl/spectrum_peak_tracker.sv
// rtl/spectrum_peak_tracker.sv - streaming per-frame peak power bin finder (optional PEAK_THRESH_EN)
module spectrum_peak_tracker #(
    parameter int DATA_W = 16,
    parameter int N_BINS = 16,
    parameter int IDX_W  = 4,
    localparam int MAG_W = 2 * DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    output logic [IDX_W-1:0]         freq,
    output logic [MAG_W-1:0]         peak_mag,
`ifdef PEAK_THRESH_EN
    input  logic [MAG_W-1:0]         thresh,
    output logic                     no_peak,
`endif
    output logic                     done
);

    typedef enum logic [0:0] {SCAN, FLUSH} state_t;

    state_t state;

    logic [IDX_W-1:0] bin_cnt;
    logic             accept;

    // stage 1 registers: power of the most recently accepted bin
    logic             s1_valid;
    logic [IDX_W-1:0] s1_idx;
    logic [MAG_W-1:0] s1_pwr;

    // stage 2 registers: running maximum of the current frame
    logic [IDX_W-1:0] max_idx;
    logic [MAG_W-1:0] max_pwr;

    logic signed [MAG_W-1:0] re_sq;
    logic signed [MAG_W-1:0] im_sq;
    logic [MAG_W-1:0]        pwr_next;
    logic                    s1_wins;
    logic [IDX_W-1:0]        final_idx;
    logic [MAG_W-1:0]        final_pwr;

    assign accept = in_valid & in_ready;

    // Each square is non-negative and at most 2**(2*DATA_W-2), so the unsigned sum is exact in MAG_W bits.
    assign re_sq    = in_re * in_re;
    assign im_sq    = in_im * in_im;
    assign pwr_next = $unsigned(re_sq) + $unsigned(im_sq);

    // Bin 0 always seeds the maximum; later bins must be strictly larger so ties keep the lower index.
    assign s1_wins   = s1_valid && ((s1_idx == '0) || (s1_pwr > max_pwr));
    assign final_idx = s1_wins ? s1_idx : max_idx;
    assign final_pwr = s1_wins ? s1_pwr : max_pwr;

    // Stage 1: square and sum the accepted bin, tagging it with its index
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_pwr   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_idx <= bin_cnt;
                s1_pwr <= pwr_next;
            end
        end
    end

    // Stage 2: fold the stage-1 bin into the running maximum
    always_ff @(posedge clk) begin
        if (rst) begin
            max_idx <= '0;
            max_pwr <= '0;
        end else if (s1_wins) begin
            max_idx <= s1_idx;
            max_pwr <= s1_pwr;
        end
    end

    // Frame FSM: count accepts in SCAN, publish the result when leaving the one-cycle FLUSH
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SCAN;
            bin_cnt  <= '0;
            in_ready <= 1'b1;
            freq     <= '0;
            peak_mag <= '0;
            done     <= 1'b0;
`ifdef PEAK_THRESH_EN
            no_peak  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                SCAN: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (bin_cnt == IDX_W'(N_BINS - 1)) begin
                            bin_cnt  <= '0;
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                        end else begin
                            bin_cnt <= bin_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state    <= SCAN;
                    in_ready <= 1'b1;
                    done     <= 1'b1;
                    peak_mag <= final_pwr;
`ifdef PEAK_THRESH_EN
                    no_peak  <= (final_pwr < thresh);
                    freq     <= (final_pwr < thresh) ? '0 : final_idx;
`else
                    freq     <= final_idx;
`endif
                end
                default: begin
                    state    <= SCAN;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
